// File: rtl/gate_eval_pipe_pkg.sv
// Shared helpers for the gate evaluation pipeline: the two gate equations,
// a popcount over a bounded vector, and the tally ceiling.
package gate_eval_pkg;

    // Widest vector popcount() accepts; callers zero-extend into it.
    localparam int unsigned POP_MAX_W = 256;

    // Widest tally that cnt_max() can describe exactly.
    localparam int unsigned CNT_MAX_LIMIT_W = 64;

    // x output equation, one bit lane.
    function automatic logic gate_x(input logic a, input logic b, input logic c);
        return ~c ^ (a | b);
    endfunction

    // y output equation, one bit lane; reduces to a & b.
    function automatic logic gate_y(input logic a, input logic b);
        return (a | b) & (~(a & b) ^ (a | b));
    endfunction

    // Number of set bits; unused upper bits must be zero.
    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            if (v[i]) begin
                n++;
            end
        end
        return n;
    endfunction

    // All-ones value of a w-bit tally (2^w - 1).
    function automatic logic [CNT_MAX_LIMIT_W-1:0] cnt_max(input int unsigned w);
        logic [CNT_MAX_LIMIT_W-1:0] m;
        if (w >= CNT_MAX_LIMIT_W) begin
            m = '1;
        end else begin
            m = (64'd1 << w) - 64'd1;
        end
        return m;
    endfunction

endpackage

// File: rtl/gate_eval_pipe_if.sv
// Operand/result handshake bundle between source, pipeline and sink.
interface gate_eval_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int XO_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [XO_W-1:0]  x_ones;

    // Source/sink side driving operands and accepting results.
    modport master (
        output in_valid, a, b, c, out_ready,
        input  in_ready, out_valid, x, y, x_ones
    );

    // Pipeline side.
    modport slave (
        input  in_valid, a, b, c, out_ready,
        output in_ready, out_valid, x, y, x_ones
    );

endinterface

// File: rtl/gate_eval_pipe_reg.sv
// Generic one-entry valid/ready register slice. Loads when empty or when the
// held entry leaves in the same cycle; data only changes on an accepted beat
// so a stalled output stays stable.
module pipe_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Next-state: take a new beat whenever the slot is free or draining.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    // Slot register with synchronous reset that discards any held beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/gate_eval_pipe.sv
// Two-stage bitwise gate evaluator with backpressure and a saturating
// tally of set bits in x over all delivered results.
module gate_eval_pipe
    import gate_eval_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    gate_eval_pipe_if.slave  bus,
    input  logic             clr_tally,
    output logic [CNT_W-1:0] tally
);

    localparam int XO_W  = $clog2(WIDTH + 1);
    localparam int S1_W  = 3 * WIDTH;
    localparam int S2_W  = 2 * WIDTH + XO_W;
    // Sum is wide enough for both operands plus a carry, so the clamp is exact.
    localparam int SUM_W = ((CNT_W > XO_W) ? CNT_W : XO_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'(cnt_max(CNT_W));

    logic             s1_in_ready;
    logic             s1_valid;
    logic [S1_W-1:0]  s1_in_data;
    logic [S1_W-1:0]  s1_data;
    logic             s2_in_ready;
    logic             s2_valid;
    logic [S2_W-1:0]  s2_in_data;
    logic [S2_W-1:0]  s2_data;

    logic [WIDTH-1:0] or_ab;
    logic [WIDTH-1:0] and_ab;
    logic [WIDTH-1:0] c_s1;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_d;
    logic [XO_W-1:0]  ones_d;
    logic [POP_MAX_W-1:0] pop_vec;

    logic [XO_W-1:0]  ones_q;
    logic             out_xfer;
    logic [CNT_W-1:0] tally_q;
    logic [CNT_W-1:0] tally_d;
    logic [SUM_W-1:0] tally_base;
    logic [SUM_W-1:0] tally_sum;

    assign s1_in_data = {bus.a | bus.b, bus.a & bus.b, bus.c};

    // in_ready is held low during reset so no beat is taken while flushing.
    assign bus.in_ready = !rst && s1_in_ready;

    pipe_reg #(
        .DW (S1_W)
    ) u_stage1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (s1_in_ready),
        .in_data_i   (s1_in_data),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_in_ready),
        .out_data_o  (s1_data)
    );

    assign or_ab  = s1_data[S1_W-1 -: WIDTH];
    assign and_ab = s1_data[2*WIDTH-1 -: WIDTH];
    assign c_s1   = s1_data[WIDTH-1:0];

    // Stage-2 result. The gate functions see the registered terms directly:
    // (or|or) = or, and (or|and) = or with (or&and) = and, so the equations
    // give the same answer as on the raw operands.
    always_comb begin
        x_d     = '0;
        y_d     = '0;
        pop_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            x_d[i] = gate_x(or_ab[i], or_ab[i], c_s1[i]);
            y_d[i] = gate_y(or_ab[i], and_ab[i]);
        end
        pop_vec[WIDTH-1:0] = x_d;
        ones_d = XO_W'(popcount(pop_vec));
    end

    assign s2_in_data = {x_d, y_d, ones_d};

    pipe_reg #(
        .DW (S2_W)
    ) u_stage2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_in_ready),
        .in_data_i   (s2_in_data),
        .out_valid_o (s2_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (s2_data)
    );

    assign bus.out_valid = s2_valid;
    assign bus.x         = s2_data[S2_W-1 -: WIDTH];
    assign bus.y         = s2_data[WIDTH+XO_W-1 -: WIDTH];
    assign ones_q        = s2_data[XO_W-1:0];
    assign bus.x_ones    = ones_q;

    assign out_xfer = s2_valid && bus.out_ready;

    // Tally next-state: clear takes effect before a same-cycle transfer adds in.
    always_comb begin
        tally_d    = tally_q;
        tally_base = clr_tally ? '0 : SUM_W'(tally_q);
        tally_sum  = tally_base + SUM_W'(ones_q);
        if (out_xfer) begin
            tally_d = (tally_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : tally_sum[CNT_W-1:0];
        end else if (clr_tally) begin
            tally_d = '0;
        end
    end

    // Tally register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tally_q <= '0;
        end else begin
            tally_q <= tally_d;
        end
    end

    assign tally = tally_q;

endmodule

// File: tb/tb_gate_eval_pipe.sv
module tb_gate_eval_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr_tally;
    logic [CNT_W-1:0] tally;

    int checks = 0;
    int errors = 0;

    gate_eval_pipe_if #(.WIDTH(WIDTH)) bus();

    gate_eval_pipe #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .clr_tally (clr_tally),
        .tally     (tally)
    );

    always #5 clk = ~clk;

    // Hand-computed stream vectors: x = ~c ^ (a|b), y = a & b.
    logic [7:0] st_a [4] = '{8'h01, 8'hFF, 8'h0F, 8'hA5};
    logic [7:0] st_b [4] = '{8'h02, 8'h00, 8'h0F, 8'h5A};
    logic [7:0] st_c [4] = '{8'h00, 8'hF0, 8'h3C, 8'h00};
    logic [7:0] ex_x [4] = '{8'hFC, 8'hF0, 8'hCC, 8'h00};
    logic [7:0] ex_y [4] = '{8'h00, 8'h00, 8'h0F, 8'h00};
    logic [3:0] ex_o [4] = '{4'd6, 4'd4, 4'd4, 4'd0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic v);
        bus.a        = a;
        bus.b        = b;
        bus.c        = c;
        bus.in_valid = v;
    endtask

    // One beat through an empty pipe with out_ready high: accept, show, transfer.
    task automatic push_one(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bus.out_ready = 1'b1;
        drive(a, b, c, 1'b1);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
    endtask

    task automatic clear_tally();
        clr_tally = 1'b1;
        step();
        clr_tally = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(8'h00, 8'h00, 8'h00, 1'b1);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b expected 0", bus.in_ready); end
        step();
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (tally !== 4'd0) begin errors++; $display("FAIL reset_tally: got %0d expected 0", tally); end
        checks++;
        if (bus.x !== 8'h00 || bus.y !== 8'h00 || bus.x_ones !== 4'd0) begin
            errors++; $display("FAIL reset_data: got x=%h y=%h ones=%0d expected 0/0/0", bus.x, bus.y, bus.x_ones);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_single_beat();
        bus.out_ready = 1'b1;
        drive(8'hF0, 8'hCC, 8'hAA, 1'b1);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_latency_early: got out_valid=%b expected 0", bus.out_valid); end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.x !== 8'hA9 || bus.y !== 8'hC0 || bus.x_ones !== 4'd4) begin
            errors++; $display("FAIL single_result: got v=%b x=%h y=%h ones=%0d expected 1 A9 C0 4", bus.out_valid, bus.x, bus.y, bus.x_ones);
        end
        checks++;
        if (tally !== 4'd0) begin errors++; $display("FAIL single_tally_before: got %0d expected 0", tally); end
        step();
        checks++;
        if (tally !== 4'd4) begin errors++; $display("FAIL single_tally: got %0d expected 4", tally); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got out_valid=%b expected 0", bus.out_valid); end
    endtask

    task automatic test_streaming();
        clear_tally();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k >= 2) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.x !== ex_x[k-2] || bus.y !== ex_y[k-2] || bus.x_ones !== ex_o[k-2]) begin
                    errors++;
                    $display("FAIL stream_beat%0d: got v=%b x=%h y=%h ones=%0d expected 1 %h %h %0d",
                             k-2, bus.out_valid, bus.x, bus.y, bus.x_ones, ex_x[k-2], ex_y[k-2], ex_o[k-2]);
                end
            end
            if (k < 4) begin
                drive(st_a[k], st_b[k], st_c[k], 1'b1);
                #1;
                checks++;
                if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready%0d: got %b expected 1", k, bus.in_ready); end
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
        end
        checks++;
        if (tally !== 4'd14) begin errors++; $display("FAIL stream_tally: got %0d expected 14", tally); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained: got out_valid=%b expected 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        int  src;
        int  snk;
        logic accept;
        src = 0;
        snk = 0;
        for (int cyc = 0; cyc < 30 && snk < 4; cyc++) begin
            bus.out_ready = (cyc >= 5);
            if (src < 4) drive(st_a[src], st_b[src], st_c[src], 1'b1);
            else         bus.in_valid = 1'b0;
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_cyc%0d: got %b expected 0", cyc, bus.in_ready); end
                checks++;
                if (bus.out_valid !== 1'b1 || bus.x !== ex_x[0] || bus.y !== ex_y[0] || bus.x_ones !== ex_o[0]) begin
                    errors++; $display("FAIL bp_hold_cyc%0d: got v=%b x=%h y=%h ones=%0d expected 1 %h %h %0d",
                                       cyc, bus.out_valid, bus.x, bus.y, bus.x_ones, ex_x[0], ex_y[0], ex_o[0]);
                end
            end
            accept = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.x !== ex_x[snk] || bus.y !== ex_y[snk] || bus.x_ones !== ex_o[snk]) begin
                    errors++; $display("FAIL bp_order%0d: got x=%h y=%h ones=%0d expected %h %h %0d",
                                       snk, bus.x, bus.y, bus.x_ones, ex_x[snk], ex_y[snk], ex_o[snk]);
                end
                snk++;
            end
            @(posedge clk);
            if (accept) src++;
            #1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (snk != 4 || src != 4) begin errors++; $display("FAIL bp_count: got delivered=%0d accepted=%0d expected 4 4", snk, src); end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got out_valid=%b expected 0", bus.out_valid); end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_t [3] = '{4'd8, 4'd15, 4'd15};
        clear_tally();
        for (int i = 0; i < 3; i++) begin
            push_one(8'h00, 8'h00, 8'h00);
            checks++;
            if (tally !== exp_t[i]) begin errors++; $display("FAIL sat_tally%0d: got %0d expected %0d", i, tally, exp_t[i]); end
        end
    endtask

    task automatic test_clear();
        clear_tally();
        push_one(8'h00, 8'h00, 8'h00);
        push_one(8'h00, 8'h00, 8'hFE);
        checks++;
        if (tally !== 4'd9) begin errors++; $display("FAIL clr_setup_tally: got %0d expected 9", tally); end
        bus.out_ready = 1'b1;
        drive(8'hF0, 8'hCC, 8'hAA, 1'b1);
        step();
        bus.in_valid = 1'b0;
        step();
        clr_tally = 1'b1;
        step();
        clr_tally = 1'b0;
        checks++;
        if (tally !== 4'd4) begin errors++; $display("FAIL clr_with_xfer: got %0d expected 4", tally); end
        clear_tally();
        checks++;
        if (tally !== 4'd0) begin errors++; $display("FAIL clr_no_xfer: got %0d expected 0", tally); end
    endtask

    task automatic test_reset_midstream();
        push_one(8'hF0, 8'hCC, 8'hAA);
        bus.out_ready = 1'b0;
        drive(st_a[0], st_b[0], st_c[0], 1'b1);
        step();
        drive(st_a[1], st_b[1], st_c[1], 1'b1);
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || tally !== 4'd4) begin
            errors++; $display("FAIL rst_mid_setup: got v=%b tally=%0d expected 1 4", bus.out_valid, tally);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 0", bus.in_ready); end
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || tally !== 4'd0 || bus.x !== 8'h00 || bus.y !== 8'h00 || bus.x_ones !== 4'd0) begin
            errors++; $display("FAIL rst_mid_state: got v=%b tally=%0d x=%h y=%h ones=%0d expected 0 0 00 00 0",
                               bus.out_valid, tally, bus.x, bus.y, bus.x_ones);
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release: got %b expected 1", bus.in_ready); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale%0d: got out_valid=%b expected 0", i, bus.out_valid); end
        end
    endtask

    initial begin
        rst           = 1'b1;
        clr_tally     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.c         = 8'h00;
        test_reset();
        test_single_beat();
        test_streaming();
        test_backpressure();
        test_saturation();
        test_clear();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gate_eval_pipe.md
# gate_eval_pipe

Parametrised, pipelined successor to the lab's 3-input gate-network exercise. Evaluates the same two-output logic network bitwise over WIDTH-bit operand vectors. Operands move through a 2-stage valid/ready pipeline with full backpressure. A saturating tally accumulates the number of set bits of `x` over all delivered results. It sits between a stimulus source, such as switch/UART capture, and a display or checker sink in the Lab_03 datapath.

## Interface
- `WIDTH`, 8: operand/result width in bits; must be 1 or more.
- `CNT_W`, 16: tally counter width; must be 1 or more.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `in_valid` input, 1 bit: operand beat present.
- `in_ready` output, 1 bit: block can accept a beat.
- `a`, `b`, `c` inputs, WIDTH bits each: operands.
- `out_valid` output, 1 bit: result beat present.
- `out_ready` input, 1 bit: sink accepts the result.
- `x` output, WIDTH bits: `~c ^ (a|b)`, bitwise.
- `y` output, WIDTH bits: `(a|b) & (~(a&b) ^ (a|b))`, bitwise; this equals `a&b` and must match it.
- `x_ones` output, $clog2(WIDTH+1) bits: popcount of `x`.
- `clr_tally` input, 1 bit: synchronous tally clear.
- `tally` output, CNT_W bits: saturating running sum of `x_ones` over transferred results.

## Operation
- Input transfer happens when `in_valid && in_ready`. Output transfer happens when `out_valid && out_ready`.
- Stage 1 registers `or_ab = a|b`, `and_ab = a&b` and `c`, plus a valid bit.
- Stage 2 registers `x`, `y` and `x_ones`, computed from the stage-1 registers, plus a valid bit. `x`/`y`/`x_ones` are driven directly from the stage-2 registers.
- Each stage loads when it is empty or when its contents leave in the same cycle.
  - `in_ready = !s1_valid || s1_advance`, where `s1_advance = !s2_valid || out_ready`.
  - There is no combinational path from `in_valid` to `out_valid`. `out_ready` reaches `in_ready` only through the expression above.
- Beats are delivered in acceptance order with no loss and no duplication.
- Tally update on an output transfer: `tally <= min(tally + x_ones, 2^CNT_W-1)`. The addition is done at CNT_W+1 bits, then clamped. Once at maximum, `tally` holds there.
- `clr_tally` without a transfer: `tally <= 0`.
- `clr_tally` in the same cycle as a transfer: the clear applies first, so `tally <= x_ones` of that transfer.
- Reset (`rst` = 1) at the next edge:
  - Both valid bits go to 0; `out_valid` = 0.
  - The data registers `x`, `y` and `x_ones` go to 0.
  - `tally` = 0.
  - In-flight beats are discarded.
  - `in_ready` is forced to 0 while `rst` is high, and is 1 on the first cycle after `rst` deasserts.

## Timing
- Latency: a beat accepted at edge N is visible with `out_valid` = 1 after edge N+1, and can transfer at edge N+2.
- Throughput: one beat per cycle while `out_ready` = 1.
- Capacity: 2 beats. With `out_ready` = 0, `in_ready` falls once both stages are full.
- Stall: while `out_valid && !out_ready`, `x`/`y`/`x_ones` are held stable.
- `tally` reflects a transfer on the cycle after that transfer's edge.

## Structure
- Package `gate_eval_pkg` holds:
  - function `gate_x(a,b,c)`;
  - function `gate_y(a,b)`;
  - a parametrised popcount function;
  - localparam `CNT_MAX` helper.
- One sub-module, `pipe_reg`: a generic valid/ready register slice with parameter `DW`. It is instantiated twice: stage 1 with DW = 3·WIDTH, stage 2 with DW = 2·WIDTH + popcount width.
- The tally logic lives in the top level.

## Test plan
- **Single beat** (WIDTH=8): a=F0, b=CC, c=AA, `out_ready`=1 → after 2 edges `out_valid`=1 with x=A9, y=C0, x_ones=4; then `tally`=4.
- **Streaming**: 4 back-to-back beats, `out_ready`=1 → 4 consecutive output cycles in order; `in_ready` stays 1; final `tally` equals the sum of the `x_ones` values.
- **Backpressure**: continuous stream with `out_ready`=0 for 5 cycles → `in_ready`=0 after 2 beats are accepted; outputs stable; on release, all beats delivered once, in order.
- **Saturation** (CNT_W=4): a=b=c=00, so x=FF and x_ones=8 → `tally` reads 8, then 15, then stays 15 on later transfers.
- **Clear during transfer**: `clr_tally`=1 while a result with x_ones=4 transfers and `tally`=9 → next `tally`=4. A clear with no transfer → 0.
- **Reset mid-stream**: `rst` pulsed while 2 beats are in flight → next cycle `out_valid`=0, `tally`=0, x/y=0. No stale beats appear after reset; `in_ready`=1 after release.
